rle_block_sequencer: RTL
========================

Name: rle_block_sequencer

Overview:
- Sequences the JPEG entropy-coding datapath for one 8x8 block at a time.
- Accepts 64 zigzag-ordered quantized coefficients, performs AC zero-run-length coding, and issues DC, AC, ZRL and EOB symbols to the Huffman coder over its ena/rdy handshake.
- Raises a flush to the coder after the final block of a scan.
- Sits between the quantizer/zigzag stage and the Huffman coder.

Parameters:
- COEF_W, 11, signed coefficient width (DC and AC).
- BLOCK_LEN, 64, coefficients per block; must be a power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- coef_ena  in  1  upstream coefficient valid
- coef_rdy  out  1  sequencer can accept a coefficient this cycle
- coef  in  COEF_W  signed quantized coefficient, zigzag order; index 0 = DC
- last_block  in  1  sampled with index 0; marks the block as final in the scan
- ena_out  out  1  symbol valid to coder
- rdy_in  in  1  coder ready; transfer = ena_out && rdy_in
- dc  out  1  symbol is DC
- in_dc  out  COEF_W  raw DC coefficient; coder performs differencing
- run  out  4  AC zero run
- size  out  4  AC magnitude category (0..10)
- in  out  10  AC ones-complement value bits, right-aligned
- flush  out  1  one-cycle pulse after the last symbol of a last_block
- block_done  out  1  one-cycle pulse when the final symbol of any block transfers

Behaviour:
- Reset values: ena_out=0, flush=0, block_done=0, dc=0, run=0, size=0, in=0, in_dc=0; idx=0, zrun=0, state=ACCEPT. coef_rdy=1 on the first cycle after rst deasserts.
- Reset mid-block discards all pending state. No partial symbol is issued afterwards.
- States:
  - ACCEPT: coef_rdy=1. On coef_ena, idx increments mod BLOCK_LEN.
  - EMIT_ZRL, EMIT_SYM, EMIT_EOB: coef_rdy=0.
  - FLUSH: coef_rdy=0.
- Transitions taken on a coefficient accepted in ACCEPT:
  - idx=0: latch in_dc=coef, dc=1, last flag=last_block; go to EMIT_SYM.
  - AC zero, idx<BLOCK_LEN-1: zrun++; stay in ACCEPT (no symbol).
  - AC nonzero: latch size/value. If zrun>=16, go to EMIT_ZRL; else go to EMIT_SYM with run=zrun.
  - AC zero at idx=BLOCK_LEN-1: go to EMIT_EOB. Pending zrun is discarded, so no ZRLs are emitted before EOB.
- EMIT_ZRL: present run=15, size=0, dc=0. On transfer, zrun-=16. If zrun>=16 afterwards, stay; else go to EMIT_SYM with run=zrun.
- EMIT_SYM: on transfer, zrun=0. Exit is the first matching case:
  - it was index BLOCK_LEN-1: block end;
  - otherwise: return to ACCEPT.
- EMIT_EOB: present run=0, size=0, dc=0. On transfer, block end.
- Block end: pulse block_done. If the last flag is set, go to FLUSH; else go to ACCEPT.
- FLUSH: wait for rdy_in=1, pulse flush for one cycle, clear the last flag, return to ACCEPT.
- Handshake:
  - ena_out is registered and asserts the cycle after the coefficient is accepted.
  - ena_out and the symbol fields hold stable until ena_out && rdy_in.
  - ena_out deasserts in the cycle after transfer unless another symbol follows. The next symbol is presented no earlier than that cycle.
- AC value encoding:
  - size = bit length of |coef|.
  - Positive coef: in = coef[size-1:0].
  - Negative coef: in = (coef-1)[size-1:0].
  - Upper bits of in are zero.
- AC coef = -1024 is clamped to -1023 (size 10).
- DC is never size-encoded here.

Decomposition:
- Shared package jpeg_pkg:
  - constants ZRL_RUN=15, EOB_RUN=0, MAX_AC_SIZE=10;
  - seq_state_t enum (ACCEPT, EMIT_ZRL, EMIT_SYM, EMIT_EOB, FLUSH).
- Sub-module vli_encoder: combinational, signed COEF_W in -> size[3:0], val[9:0], including the clamp.
- Sequencer top holds the FSM, idx/zrun counters and output registers.

Test Plan:
- Block with DC=-5 and all AC=0, rdy_in tied 1 -> exactly two transfers: (dc=1, in_dc=-5), then EOB (run=0, size=0); block_done pulses once; no flush.
- AC[1]=3, AC[2]=-3, rest 0 -> DC, then (run0, size2, in=11), then (run0, size2, in=00), then EOB.
- AC[1..35]=0, AC[36]=1 -> DC, ZRL, ZRL, (run3, size1, in=1), EOB. AC[63]=-1024 in the same block instead of EOB -> (run.., size10, in=0000000000), no EOB.
- last_block=1 with rdy_in low for 5 cycles after the EOB transfer -> flush pulses exactly once, in the first cycle rdy_in=1. The next block's coef_rdy rises only after the flush pulse.
- Random rdy_in stalls plus coef_ena bubbles across 10 blocks -> symbol stream matches the reference model; ena_out fields stable while stalled; coef_rdy=0 in all emit states.
- rst asserted mid-block (idx=20, zrun=19) -> all outputs return to reset values; the next coefficient is treated as DC.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared types and constants for the JPEG entropy-coding sequencer slice.
package jpeg_pkg;

  localparam logic [3:0]  ZRL_RUN     = 4'd15;
  localparam logic [3:0]  EOB_RUN     = 4'd0;
  localparam int unsigned MAX_AC_SIZE = 10;

  typedef enum logic [2:0] {
    ACCEPT,
    EMIT_ZRL,
    EMIT_SYM,
    EMIT_EOB,
    FLUSH
  } seq_state_t;

endpackage

// File: rtl/vli_encoder.sv
// Variable-length-integer split of a signed AC coefficient into its JPEG
// magnitude category and ones-complement value bits.
module vli_encoder
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W = 11
) (
  input  logic [COEF_W-1:0]      coef,
  output logic [3:0]             size,
  output logic [MAX_AC_SIZE-1:0] val
);

  localparam logic [COEF_W-1:0] MOST_NEG = {1'b1, {(COEF_W-1){1'b0}}};
  localparam logic [COEF_W-1:0] ONE      = COEF_W'(1);

  logic [COEF_W-1:0] clamped;
  logic [COEF_W-1:0] mag;
  logic [COEF_W-1:0] raw;

  // Clamp the most-negative code, then derive category and value bits.
  always_comb begin
    clamped = coef;
    if (coef == MOST_NEG) clamped = coef + ONE;
    mag  = clamped[COEF_W-1] ? (~clamped + ONE) : clamped;
    raw  = clamped[COEF_W-1] ? (clamped - ONE) : clamped;
    size = '0;
    for (int unsigned i = 0; i < MAX_AC_SIZE; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    val = '0;
    for (int unsigned i = 0; i < MAX_AC_SIZE; i++) begin
      val[i] = raw[i] && (4'(i) < size);
    end
  end

endmodule

// File: rtl/rle_block_sequencer.sv
// Per-block JPEG entropy sequencer: accepts 64 zigzag coefficients, run-length
// codes the AC zeros and hands DC/AC/ZRL/EOB symbols to the Huffman coder.
module rle_block_sequencer
  import jpeg_pkg::*;
#(
  parameter int unsigned COEF_W    = 11,
  parameter int unsigned BLOCK_LEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              coef_ena,
  output logic              coef_rdy,
  input  logic [COEF_W-1:0] coef,
  input  logic              last_block,
  output logic              ena_out,
  input  logic              rdy_in,
  output logic              dc,
  output logic [COEF_W-1:0] in_dc,
  output logic [3:0]        run,
  output logic [3:0]        size,
  output logic [9:0]        in,
  output logic              flush,
  output logic              block_done
);

  localparam int unsigned    IDX_W    = $clog2(BLOCK_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLOCK_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] ZRL_SPAN = IDX_W'(16);

  seq_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] zrun;
  logic [IDX_W-1:0] zrun_after_zrl;
  logic             last_flag;
  logic [3:0]       hold_size;
  logic [9:0]       hold_val;
  logic [3:0]       vli_size;
  logic [9:0]       vli_val;
  logic             xfer;

  vli_encoder #(.COEF_W(COEF_W)) u_vli (
    .coef (coef),
    .size (vli_size),
    .val  (vli_val)
  );

  // Handshake qualifiers; flush is the coder-side transfer out of FLUSH.
  always_comb begin
    xfer           = ena_out && rdy_in;
    coef_rdy       = (state == ACCEPT);
    flush          = (state == FLUSH) && rdy_in;
    zrun_after_zrl = zrun - ZRL_SPAN;
  end

  // Sequencer FSM with index/run counters and registered symbol fields.
  // idx has already wrapped to 0 when the symbol came from the last index,
  // which is how EMIT_SYM recognises the end of a block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ACCEPT;
      idx        <= '0;
      zrun       <= '0;
      last_flag  <= 1'b0;
      hold_size  <= '0;
      hold_val   <= '0;
      ena_out    <= 1'b0;
      block_done <= 1'b0;
      dc         <= 1'b0;
      in_dc      <= '0;
      run        <= '0;
      size       <= '0;
      in         <= '0;
    end else begin
      block_done <= 1'b0;
      case (state)
        ACCEPT: begin
          if (coef_ena) begin
            idx <= idx + IDX_ONE;
            if (idx == '0) begin
              in_dc     <= coef;
              dc        <= 1'b1;
              run       <= '0;
              size      <= '0;
              in        <= '0;
              zrun      <= '0;
              last_flag <= last_block;
              ena_out   <= 1'b1;
              state     <= EMIT_SYM;
            end else if (coef == '0) begin
              if (idx == IDX_LAST) begin
                dc      <= 1'b0;
                run     <= EOB_RUN;
                size    <= '0;
                in      <= '0;
                zrun    <= '0;
                ena_out <= 1'b1;
                state   <= EMIT_EOB;
              end else begin
                zrun <= zrun + IDX_ONE;
              end
            end else begin
              hold_size <= vli_size;
              hold_val  <= vli_val;
              dc        <= 1'b0;
              ena_out   <= 1'b1;
              if (zrun >= ZRL_SPAN) begin
                run   <= ZRL_RUN;
                size  <= '0;
                in    <= '0;
                state <= EMIT_ZRL;
              end else begin
                run   <= zrun[3:0];
                size  <= vli_size;
                in    <= vli_val;
                state <= EMIT_SYM;
              end
            end
          end
        end
        EMIT_ZRL: begin
          if (xfer) begin
            zrun <= zrun_after_zrl;
            if (zrun_after_zrl < ZRL_SPAN) begin
              run   <= zrun_after_zrl[3:0];
              size  <= hold_size;
              in    <= hold_val;
              state <= EMIT_SYM;
            end
          end
        end
        EMIT_SYM: begin
          if (xfer) begin
            zrun    <= '0;
            ena_out <= 1'b0;
            if (idx == '0) begin
              block_done <= 1'b1;
              state      <= last_flag ? FLUSH : ACCEPT;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        EMIT_EOB: begin
          if (xfer) begin
            ena_out    <= 1'b0;
            block_done <= 1'b1;
            state      <= last_flag ? FLUSH : ACCEPT;
          end
        end
        FLUSH: begin
          if (rdy_in) begin
            last_flag <= 1'b0;
            state     <= ACCEPT;
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

endmodule
